// File: rtl/wb_stage_if.sv
// wb_stage_if: execution-pipe results in, register-file write
// ports and status flags out, for the writeback alignment stage.
interface wb_stage_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128,
  parameter int LAT_W  = 4
);
  logic              flush;
  logic              ev_res_valid;
  logic [LAT_W-1:0]  ev_res_lat;
  logic [ADDR_W-1:0] ev_res_addr;
  logic [DATA_W-1:0] ev_res_data;
  logic              od_res_valid;
  logic [LAT_W-1:0]  od_res_lat;
  logic [ADDR_W-1:0] od_res_addr;
  logic [DATA_W-1:0] od_res_data;
  logic              reg_write_en_1;
  logic [ADDR_W-1:0] reg_write_addr_1;
  logic [DATA_W-1:0] reg_write_data_1;
  logic              reg_write_en_2;
  logic [ADDR_W-1:0] reg_write_addr_2;
  logic [DATA_W-1:0] reg_write_data_2;
  logic              pending;
  logic              lat_err;
  logic              coll_err;

  modport master (
    output flush,
    output ev_res_valid, ev_res_lat,
    output ev_res_addr, ev_res_data,
    output od_res_valid, od_res_lat,
    output od_res_addr, od_res_data,
    input  reg_write_en_1, reg_write_addr_1,
    input  reg_write_data_1,
    input  reg_write_en_2, reg_write_addr_2,
    input  reg_write_data_2,
    input  pending, lat_err, coll_err
  );

  modport slave (
    input  flush,
    input  ev_res_valid, ev_res_lat,
    input  ev_res_addr, ev_res_data,
    input  od_res_valid, od_res_lat,
    input  od_res_addr, od_res_data,
    output reg_write_en_1, reg_write_addr_1,
    output reg_write_data_1,
    output reg_write_en_2, reg_write_addr_2,
    output reg_write_data_2,
    output pending, lat_err, coll_err
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: delays even/odd pipe results so every instruction
// retires DEPTH cycles after issue, then drives the RF write ports.
module wb_stage #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128,
  parameter int LAT_W  = 4
) (
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } slot_t;

  // index 0 = even pipe, 1 = odd pipe
  slot_t             r_slot [2][DEPTH];
  slot_t             w_nxt  [2][DEPTH];
  logic              r_lat_err;
  logic              r_coll_err;
  logic [1:0]        w_vld;
  logic [LAT_W-1:0]  w_lat  [2];
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_data [2];
  logic [LAT_W-1:0]  w_k    [2];
  logic [1:0]        w_ok;
  logic [1:0]        w_bad;
  logic [1:0]        w_coll;
  logic              w_waw;
  logic              w_pend;

  assign w_vld     = {bus.od_res_valid, bus.ev_res_valid};
  assign w_lat[0]  = bus.ev_res_lat;
  assign w_lat[1]  = bus.od_res_lat;
  assign w_addr[0] = bus.ev_res_addr;
  assign w_addr[1] = bus.od_res_addr;
  assign w_data[0] = bus.ev_res_data;
  assign w_data[1] = bus.od_res_data;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_ok[p]   = w_vld[p] && (w_lat[p] != '0) &&
                  (w_lat[p] <= LAT_W'(DEPTH));
      w_bad[p]  = w_vld[p] && !w_ok[p];
      w_k[p]    = LAT_W'(DEPTH) - w_lat[p];
      w_coll[p] = 1'b0;
      for (int s = 0; s < DEPTH; s++)
        w_nxt[p][s] = '0;
      for (int s = 0; s < DEPTH-1; s++) begin
        w_nxt[p][s] = r_slot[p][s+1];
        if (w_ok[p] && w_k[p] == LAT_W'(s) &&
            r_slot[p][s+1].v)
          w_coll[p] = 1'b1;
      end
      // the new result overwrites whatever shifted in
      for (int s = 0; s < DEPTH; s++)
        if (w_ok[p] && w_k[p] == LAT_W'(s))
          w_nxt[p][s] = {1'b1, w_addr[p], w_data[p]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < DEPTH; s++)
          r_slot[p][s] <= '0;
      r_lat_err  <= 1'b0;
      r_coll_err <= 1'b0;
    end else if (bus.flush) begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < DEPTH; s++)
          r_slot[p][s] <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < DEPTH; s++)
          r_slot[p][s] <= w_nxt[p][s];
      r_lat_err  <= r_lat_err | (|w_bad);
      r_coll_err <= r_coll_err | (|w_coll);
    end
  end

  always_comb begin
    w_pend = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < DEPTH; s++)
        w_pend = w_pend | r_slot[p][s].v;
  end

  // odd pipe is younger; a same-address pair only lands the odd write
  assign w_waw = r_slot[1][0].v &&
                 (r_slot[1][0].a == r_slot[0][0].a);

  assign bus.reg_write_en_1   = r_slot[0][0].v && !w_waw;
  assign bus.reg_write_addr_1 = r_slot[0][0].a;
  assign bus.reg_write_data_1 = r_slot[0][0].d;
  assign bus.reg_write_en_2   = r_slot[1][0].v;
  assign bus.reg_write_addr_2 = r_slot[1][0].a;
  assign bus.reg_write_data_2 = r_slot[1][0].d;
  assign bus.pending          = w_pend;
  assign bus.lat_err          = r_lat_err;
  assign bus.coll_err         = r_coll_err;
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback alignment stage sitting directly upstream of the SPU register file's two write ports.
- Takes completed results from the even and odd execution pipes. Each result carries a latency tag giving the cycles it has already spent in its unit.
- Delays each result so every instruction retires a fixed DEPTH cycles after issue.
- Drives the register file's write enable, address and data for port 1 (even pipe) and port 2 (odd pipe). Also handles flushes, same-slot collisions and same-address dual writes.

Parameters:
- DEPTH, 8, staging slots per pipe; total issue-to-writeback latency.
- ADDR_W, 7, register address width (128 registers).
- DATA_W, 128, register data width.
- LAT_W, 4, latency-tag width; must hold the value DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all in-flight results.
- ev_res_valid  in  1  even-pipe result present this cycle.
- ev_res_lat  in  LAT_W  cycles the even result has already spent in its unit; legal range 1..DEPTH.
- ev_res_addr  in  ADDR_W  even-pipe destination register.
- ev_res_data  in  DATA_W  even-pipe result.
- od_res_valid, od_res_lat, od_res_addr, od_res_data  in  1/LAT_W/ADDR_W/DATA_W  same fields for the odd pipe.
- reg_write_en_1  out  1  even-pipe writeback enable.
- reg_write_addr_1  out  ADDR_W  even-pipe writeback address.
- reg_write_data_1  out  DATA_W  even-pipe writeback data.
- reg_write_en_2, reg_write_addr_2, reg_write_data_2  out  1/ADDR_W/DATA_W  same fields for the odd pipe.
- pending  out  1  any staging slot in either pipe valid.
- lat_err  out  1  sticky: a result arrived with an illegal latency tag.
- coll_err  out  1  sticky: two results in one pipe targeted the same slot.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Storage: each pipe has DEPTH slots, index 0..DEPTH-1. Each slot holds valid, addr and data.
- Slot 0 of each pipe is the registered writeback output for that pipe.
- Reset values:
  - All slot valid bits 0, addr 0, data 0.
  - All outputs 0, including lat_err, coll_err and pending.
  - rst has priority over flush and over all inputs.
- Shift, every cycle per pipe:
  - slot[s] <= slot[s+1] for s < DEPTH-1.
  - slot[DEPTH-1] <= invalid.
- Insert, per pipe, when res_valid=1 and 1 <= lat <= DEPTH:
  - Target slot k = DEPTH-lat.
  - At the edge, slot[k] <= {1, addr, data}, replacing the shifted-in value.
- Latency: a result presented in cycle t with tag lat drives its reg_write_en in cycle t+1+DEPTH-lat, for exactly one cycle.
- Collision: insert when the shifted-in slot[k+1] (k < DEPTH-1) is valid.
  - New result wins; the older result is lost.
  - coll_err <= 1 at that edge.
- Illegal latency: lat = 0 or lat > DEPTH with res_valid=1.
  - Result dropped; lat_err <= 1 at that edge.
- Sticky error flags clear only on rst.
- Invalid slots carry addr=0 and data=0, so reg_write_addr/data read 0 whenever the matching en is 0.
- Outputs:
  - reg_write_en_2, reg_write_addr_2 and reg_write_data_2 come straight from odd slot 0.
  - reg_write_addr_1 and reg_write_data_1 come straight from even slot 0.
  - reg_write_en_1 = even slot0.valid AND NOT(odd slot0.valid AND odd slot0.addr == even slot0.addr).
  - This WAW rule applies because the odd pipe is later in program order and is the only write that lands.
- Flush, when flush=1 and rst=0:
  - All slots in both pipes become invalid (addr/data zeroed) at the edge.
  - Results presented in the flush cycle are dropped, and no error flags are set by them.
  - The write already visible during the flush cycle still completes.
- pending: combinational OR of all slot valid bits in both pipes, including slot 0.
- Pipes are independent. Both pipes may insert, collide or retire in the same cycle.

Test Plan:
- Reset check: rst=1 for 2 cycles with random inputs driven -> all outputs 0. Release rst -> outputs stay 0 with no results issued.
- Minimum delay: cycle 0 ev_res_valid=1, lat=8, addr=5, data=128'hA5 -> cycle 1 en_1=1, addr_1=5, data_1=128'hA5. Cycle 2 en_1=0 and addr/data 0.
- Maximum delay plus odd pipe: cycle 0 od lat=1, addr=10, data=128'h1234 -> en_2=1 only in cycle 8. pending=1 in cycles 1..8 and 0 in cycle 9.
- Collision: cycle 0 even lat=2, addr=1; cycle 1 even lat=3, addr=2 -> coll_err=1 from cycle 2. en_1 in cycle 7 with addr=2. addr=1 never written.
- WAW and illegal tag:
  - Cycle 0 even and odd both lat=8, addr=20, data 128'h1 and 128'h2 -> cycle 1 en_2=1 with data=128'h2, en_1=0.
  - Later, od lat=0 -> dropped, lat_err=1 next cycle.
- Flush: cycle 0 even lat=2, addr=3; cycle 3 flush=1 with od lat=8 presented -> no writeback ever occurs. pending=0 from cycle 4. coll_err and lat_err remain 0.
